// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port controller: sweeps every register to INIT_VALUE after reset,
// then arbitrates WB (priority) against debug, forcing a one-cycle stall when debug starves.
module regfile_wport_arbiter #(
    parameter int                    ADDR_SIZE    = 5,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    parameter int                    STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  init_req,
    input  logic                  wb_we,
    input  logic [ADDR_SIZE-1:0]  wb_wa,
    input  logic [DATA_WIDTH-1:0] wb_wd,
    input  logic                  dbg_req,
    input  logic [ADDR_SIZE-1:0]  dbg_wa,
    input  logic [DATA_WIDTH-1:0] dbg_wd,
    output logic                  dbg_ack,
    output logic                  stall_req,
    output logic                  init_busy,
    output logic                  rf_we,
    output logic [ADDR_SIZE-1:0]  rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd
);

    localparam int                   SCNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_SIZE-1:0] IDX_LAST  = {ADDR_SIZE{1'b1}};
    localparam logic [ADDR_SIZE-1:0] IDX_ONE   = ADDR_SIZE'(32'd1);
    localparam logic [SCNT_W-1:0]    SCNT_ONE  = SCNT_W'(32'd1);
    localparam logic [SCNT_W-1:0]    SCNT_LAST = SCNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                  state_q, state_d, nxt_state_s;
    logic [ADDR_SIZE-1:0]    idx_q, idx_d, nxt_idx_s;
    logic [SCNT_W-1:0]       scnt_q, scnt_d, nxt_scnt_s;
    logic                    dbg_sel_s;
    logic                    port_we_s;
    logic [ADDR_SIZE-1:0]    port_wa_s;
    logic [DATA_WIDTH-1:0]   port_wd_s;

    // State, sweep index and starvation counter
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
        end
    end

    // Arbitration and next-state selection; init_req overrides everything
    always_comb begin
        nxt_state_s = state_q;
        nxt_idx_s   = idx_q;
        nxt_scnt_s  = '0;
        dbg_sel_s   = 1'b0;
        port_we_s   = 1'b0;
        port_wa_s   = wb_wa;
        port_wd_s   = wb_wd;
        case (state_q)
            ST_SWEEP: begin
                port_we_s = 1'b1;
                port_wa_s = idx_q;
                port_wd_s = INIT_VALUE;
                nxt_idx_s = idx_q + IDX_ONE;
                if (idx_q == IDX_LAST) begin
                    nxt_state_s = ST_RUN;
                end else begin
                    nxt_state_s = ST_SWEEP;
                end
            end
            ST_RUN: begin
                if (wb_we) begin
                    port_we_s = 1'b1;
                    if (dbg_req) begin
                        nxt_scnt_s = scnt_q + SCNT_ONE;
                        if (scnt_q == SCNT_LAST) begin
                            nxt_state_s = ST_STALL;
                        end else begin
                            nxt_state_s = ST_RUN;
                        end
                    end else begin
                        nxt_scnt_s = '0;
                    end
                end else begin
                    dbg_sel_s = dbg_req;
                end
            end
            ST_STALL: begin
                // WB is ignored here even if it still asserts wb_we
                dbg_sel_s   = dbg_req;
                nxt_state_s = ST_RUN;
            end
            default: begin
                nxt_state_s = ST_SWEEP;
                nxt_idx_s   = '0;
            end
        endcase

        if (init_req) begin
            state_d = ST_SWEEP;
            idx_d   = '0;
            scnt_d  = '0;
        end else begin
            state_d = nxt_state_s;
            idx_d   = nxt_idx_s;
            scnt_d  = nxt_scnt_s;
        end
    end

    // Write-port mux; a debug write to register 0 is acked but never reaches the file
    always_comb begin
        dbg_ack = dbg_sel_s & ~init_req;
        if (dbg_ack) begin
            rf_we = |dbg_wa;
            rf_wa = dbg_wa;
            rf_wd = dbg_wd;
        end else begin
            rf_we = port_we_s;
            rf_wa = port_wa_s;
            rf_wd = port_wd_s;
        end
    end

    assign stall_req = (state_q == ST_STALL);
    assign init_busy = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed sweep/init/reset sequences,
// a vector table for arbitration corners, and a random run against a counting model.
module tb_regfile_wport_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int NREG  = 32;

    logic          CLK = 1'b0;
    logic          rst;
    logic          init_req;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;
    logic          dbg_req;
    logic [AW-1:0] dbg_wa;
    logic [DW-1:0] dbg_wd;
    logic          dbg_ack;
    logic          stall_req;
    logic          init_busy;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] rf_mem  [NREG];
    logic [DW-1:0] ref_mem [NREG];

    // Reference model: cycles of sweep left, length of the current blocked run, stall flag
    int            sweep_left;
    int            blocked;
    bit            stall_now;
    logic          e_we, e_ack, e_stall, e_busy;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          last_ack;
    bit            found;

    typedef struct {
        logic          wb_we;
        logic [AW-1:0] wb_wa;
        logic [DW-1:0] wb_wd;
        logic          dbg_req;
        logic [AW-1:0] dbg_wa;
        logic [DW-1:0] dbg_wd;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic          e_ack;
        logic          e_stall;
    } vec_t;

    vec_t tbl [10];

    regfile_wport_arbiter #(
        .ADDR_SIZE   (AW),
        .DATA_WIDTH  (DW),
        .INIT_VALUE  (32'h0000_0000),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .init_req (init_req),
        .wb_we    (wb_we),
        .wb_wa    (wb_wa),
        .wb_wd    (wb_wd),
        .dbg_req  (dbg_req),
        .dbg_wa   (dbg_wa),
        .dbg_wd   (dbg_wd),
        .dbg_ack  (dbg_ack),
        .stall_req(stall_req),
        .init_busy(init_busy),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd)
    );

    always #5 CLK = ~CLK;

    // Register file stand-in: commits on the negedge of the cycle the port is driven
    always @(negedge CLK) begin
        if (rf_we === 1'b1) rf_mem[rf_wa] <= rf_wd;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_left = NREG;
        blocked    = 0;
        stall_now  = 1'b0;
    endtask

    task automatic model_eval();
        e_we = 1'b0; e_wa = '0; e_wd = '0; e_ack = 1'b0; e_stall = 1'b0; e_busy = 1'b0;
        if (sweep_left > 0) begin
            e_busy = 1'b1;
            e_we   = 1'b1;
            e_wa   = AW'(NREG - sweep_left);
            e_wd   = 32'h0000_0000;
        end else begin
            e_stall = stall_now;
            if (!stall_now && wb_we) begin
                e_we = 1'b1; e_wa = wb_wa; e_wd = wb_wd;
            end else if (dbg_req && !init_req) begin
                e_ack = 1'b1;
                e_we  = (dbg_wa != 5'd0);
                e_wa  = dbg_wa;
                e_wd  = dbg_wd;
            end
        end
    endtask

    task automatic model_step();
        if (e_we) ref_mem[e_wa] = e_wd;
        if (init_req) begin
            model_reset();
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (stall_now) begin
            stall_now = 1'b0;
            blocked   = 0;
        end else if (wb_we && dbg_req) begin
            blocked++;
            if (blocked == LIMIT) stall_now = 1'b1;
        end else begin
            blocked = 0;
        end
    endtask

    task automatic sample(input bit use_model);
        @(negedge CLK);
        model_eval();
        if (use_model) begin
            chk("m_rf_we", DW'(rf_we), DW'(e_we));
            chk("m_dbg_ack", DW'(dbg_ack), DW'(e_ack));
            chk("m_stall_req", DW'(stall_req), DW'(e_stall));
            chk("m_init_busy", DW'(init_busy), DW'(e_busy));
            if (e_we) begin
                chk("m_rf_wa", DW'(rf_wa), DW'(e_wa));
                chk("m_rf_wd", rf_wd, e_wd);
            end else if (e_ack) begin
                chk("m_ack_wa", DW'(rf_wa), DW'(e_wa));
            end
        end
        last_ack = dbg_ack;
    endtask

    task automatic advance();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'h0000_00A5, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'h0000_0000, 1'b1, 5'd7, 32'h0000_00A5, 1'b1, 5'd7, 32'h0000_00A5, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd9, 32'h0000_0022, 1'b1, 5'd3, 32'h0000_0011, 1'b0, 1'b0};
        tbl[3] = tbl[2];
        tbl[4] = tbl[2];
        tbl[5] = tbl[2];
        tbl[6] = '{1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd9, 32'h0000_0022, 1'b1, 5'd9, 32'h0000_0022, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 32'h0000_0000, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'h0000_0000, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 1'b0};

        for (int i = 0; i < NREG; i++) begin
            rf_mem[i]  = 32'hFFFF_FFFF;
            ref_mem[i] = 32'hFFFF_FFFF;
        end
        rst = 1'b0; init_req = 1'b0;
        wb_we = 1'b1; wb_wa = 5'd9; wb_wd = 32'h0000_0BAD;
        dbg_req = 1'b1; dbg_wa = 5'd3; dbg_wd = 32'h0000_CAFE;
        last_ack = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_init_busy", DW'(init_busy), 32'd1);
        chk("rst_rf_we", DW'(rf_we), 32'd1);
        chk("rst_rf_wa", DW'(rf_wa), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_dbg_ack", DW'(dbg_ack), 32'd0);
        chk("rst_stall_req", DW'(stall_req), 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0;

        // Power-on sweep with WB/debug requests that must be ignored
        for (int i = 0; i < NREG; i++) begin
            wb_we = (i % 2 == 0);
            sample(1'b1);
            chk("sweep_rf_wa", DW'(rf_wa), DW'(i));
            advance();
        end
        wb_we = 1'b0; dbg_req = 1'b0;
        sample(1'b1);
        chk("sweep_done_busy", DW'(init_busy), 32'd0);
        for (int i = 0; i < NREG; i++) chk("sweep_mem_zero", rf_mem[i], 32'd0);
        advance();

        // init_req in RUN with a pending debug write: restart, no ack
        init_req = 1'b1; dbg_req = 1'b1; dbg_wa = 5'd4; dbg_wd = 32'd77;
        sample(1'b1);
        chk("init_run_ack", DW'(dbg_ack), 32'd0);
        advance();
        init_req = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sample(1'b1);
            chk("resweep_rf_wa", DW'(rf_wa), DW'(i));
            advance();
        end
        init_req = 1'b1;
        sample(1'b1);
        chk("init_at17_wa", DW'(rf_wa), 32'd17);
        advance();
        init_req = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (i == NREG - 1) dbg_req = 1'b0;
            sample(1'b1);
            chk("restart_busy", DW'(init_busy), 32'd1);
            chk("restart_rf_wa", DW'(rf_wa), DW'(i));
            advance();
        end
        sample(1'b1);
        chk("restart_done_busy", DW'(init_busy), 32'd0);
        advance();

        // Arbitration vector table
        for (int i = 0; i < 10; i++) begin
            wb_we = tbl[i].wb_we; wb_wa = tbl[i].wb_wa; wb_wd = tbl[i].wb_wd;
            dbg_req = tbl[i].dbg_req; dbg_wa = tbl[i].dbg_wa; dbg_wd = tbl[i].dbg_wd;
            sample(1'b1);
            chk("tbl_rf_we", DW'(rf_we), DW'(tbl[i].e_we));
            chk("tbl_dbg_ack", DW'(dbg_ack), DW'(tbl[i].e_ack));
            chk("tbl_stall_req", DW'(stall_req), DW'(tbl[i].e_stall));
            chk("tbl_init_busy", DW'(init_busy), 32'd0);
            if (tbl[i].e_we) begin
                chk("tbl_rf_wa", DW'(rf_wa), DW'(tbl[i].e_wa));
                chk("tbl_rf_wd", rf_wd, tbl[i].e_wd);
            end
            advance();
            if (i == 7) chk("reg0_still_zero", rf_mem[0], 32'd0);
        end

        // Random traffic; debug requester holds its request until acked
        wb_we = 1'b0; dbg_req = 1'b0; init_req = 1'b0; last_ack = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!dbg_req || last_ack) begin
                dbg_req = ($urandom_range(0, 2) != 0);
                dbg_wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
                dbg_wd  = $urandom;
            end
            wb_we    = ($urandom_range(0, 3) != 0);
            wb_wa    = AW'($urandom);
            wb_wd    = $urandom;
            init_req = ($urandom_range(0, 199) == 0);
            sample(1'b1);
            advance();
        end
        init_req = 1'b0;
        for (int i = 0; i < NREG; i++) chk("rand_mem", rf_mem[i], ref_mem[i]);

        // Drive into STALL, then assert reset inside it
        wb_we = 1'b1; dbg_req = 1'b1; dbg_wa = 5'd12; dbg_wd = 32'h0000_5A5A;
        found = 1'b0;
        for (int c = 0; c < 48 && !found; c++) begin
            sample(1'b1);
            advance();
            found = stall_now;
        end
        chk("reach_stall", DW'(found), 32'd1);
        chk("stall_before_rst", DW'(stall_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_stall_stall", DW'(stall_req), 32'd0);
        chk("rst_mid_stall_ack", DW'(dbg_ack), 32'd0);
        chk("rst_mid_stall_busy", DW'(init_busy), 32'd1);
        chk("rst_mid_stall_wa", DW'(rf_wa), 32'd0);
        model_reset();
        @(posedge CLK); #1;
        rst = 1'b0; wb_we = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < NREG + 2; i++) begin
            sample(1'b1);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Write-port controller for the pipelined CPU's 32×32 register file. After reset it sweeps every register to a known value, then shares the single write port between the pipeline writeback stage and a debug/loader requester. The writeback stage has priority, and a starvation guard stalls the pipeline so debug writes always complete. It sits between the WB stage, the debug interface and the register file's WE3/WA3/WD3 inputs.

## Interface
Parameters:
- ADDR_SIZE, 5, register address width; sweep covers 2**ADDR_SIZE entries
- DATA_WIDTH, 32, register data width
- INIT_VALUE, 0, value written to every register during the sweep
- STARVE_LIMIT, 4, consecutive blocked debug cycles before a pipeline stall is forced (≥1)

Ports:
- CLK  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- init_req  in  1  pulse; restarts the sweep
- wb_we  in  1  writeback write enable
- wb_wa  in  ADDR_SIZE  writeback address
- wb_wd  in  DATA_WIDTH  writeback data
- dbg_req  in  1  debug write request; held until acked
- dbg_wa  in  ADDR_SIZE  debug address
- dbg_wd  in  DATA_WIDTH  debug data
- dbg_ack  out  1  debug write accepted this cycle
- stall_req  out  1  pipeline must hold; WB must not write
- init_busy  out  1  sweep in progress; pipeline held
- rf_we  out  1  to register file WE3
- rf_wa  out  ADDR_SIZE  to register file WA3
- rf_wd  out  DATA_WIDTH  to register file WD3

## Operation
- States: SWEEP, RUN, STALL. Registered: state, sweep index idx, starve counter scnt.
- Reset (async): state=SWEEP, idx=0, scnt=0.
- SWEEP: rf_we=1, rf_wa=idx, rf_wd=INIT_VALUE, init_busy=1, dbg_ack=0, stall_req=0. wb_we and dbg_req are ignored. idx increments each cycle. At idx=2**ADDR_SIZE-1, the next state is RUN and idx wraps to 0.
- RUN, wb_we=1: the port goes to WB (rf_we=1, rf_wa=wb_wa, rf_wd=wb_wd). If dbg_req=1, the request is blocked and scnt increments. If scnt=STARVE_LIMIT-1 while blocked, the next state is STALL.
- RUN, wb_we=0, dbg_req=1: the port goes to debug and dbg_ack=1. scnt clears.
- RUN, neither request: rf_we=0. scnt clears when dbg_req=0.
- STALL (exactly one cycle): stall_req=1. If dbg_req=1, the port goes to debug and dbg_ack=1. If dbg_req=0, no write occurs. wb_we is ignored. scnt clears and the next state is RUN.
- Debug write to address 0: acked with rf_we=0. WB writes to address 0 pass through unchanged.
- init_req=1 in any state sets the next state to SWEEP with idx=0. A request mid-sweep restarts the sweep from 0. A debug write pending in the same cycle is not acked.
- rf_we/rf_wa/rf_wd and dbg_ack are combinational from state and inputs. stall_req and init_busy are decoded from state only.

## Timing
- Output values under reset: init_busy=1, rf_we=1, rf_wa=0, rf_wd=INIT_VALUE, dbg_ack=0, stall_req=0.
- The sweep takes 2**ADDR_SIZE cycles (32 by default). init_busy falls on the first RUN cycle.
- The register file commits on the negedge of the same cycle the mux drives it, so write latency through this block is zero cycles.
- Handshake: debug data is consumed in the cycle where dbg_req=1 and dbg_ack=1. The requester may change dbg_wa/dbg_wd or drop dbg_req in the next cycle.
- Worst-case debug latency after leaving SWEEP: STARVE_LIMIT+1 cycles.
- stall_req is high only in STALL. The pipeline must deassert wb_we in that cycle; if it does not, that WB write is lost.
- rst asserted mid-operation immediately returns the block to SWEEP, idx=0. Partial state is discarded.

## Test plan
- Reset then idle for 32 cycles → rf_wa steps 0..31 with rf_we=1 and rf_wd=0. init_busy falls on cycle 32, and the register file reads all zeros.
- In RUN, wb_we=1, wb_wa=5, wb_wd=0xDEADBEEF while dbg_req=1 → WB is written and dbg_ack=0. With wb_we=0 on the next cycle → dbg_ack=1 and rf_wa=dbg_wa.
- wb_we held at 1 with dbg_req=1 for STARVE_LIMIT=4 cycles → stall_req=1 on cycle 5, dbg_ack=1 and rf_wd=dbg_wd, then RUN resumes.
- Debug write to address 0 with dbg_wd=0x1234 → dbg_ack=1, rf_we=0, and reading register 0 returns 0.
- init_req pulse at sweep idx=17 → idx restarts at 0 and init_busy stays high for 32 more cycles.
- rst asserted mid-STALL → state=SWEEP, stall_req=0, and dbg_ack=0 immediately, without waiting for a clock.
